hazard_control_unit: RTL and testbench

- Parametrised successor to the single-cycle hazard detector for the 5-stage pipeline.
- Detects load-use data hazards between ID and EX and issues a one-cycle stall plus bubble.
- On a taken branch in EX, issues a multi-cycle flush of configurable length.
- Holds the pipeline across variable-latency memory accesses, with a timeout watchdog and a saturating stall-cycle counter.
- Sits beside the pipeline registers; drives PC/IF-ID hold, ID-EX bubble and IF-ID/ID-EX flush.

---
 rtl/hazard_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller for the 5-stage core. Detects load-use hazards
//   between ID and EX, flushes IF/ID and ID/EX for FLUSH_CYCLES cycles after a
//   taken branch, and holds the pipeline while a memory access is outstanding.
//   A watchdog flags over-long memory waits, and a saturating counter records
//   the total number of stalled cycles.
//
// Ports
//   clock, reset_n     : rising-edge clock, asynchronous active-low reset
//   id_rs1/id_rs2      : ID source registers, qualified by id_uses_rs1/2
//   ex_rd, ex_memread  : EX destination register and load flag
//   ex_opcode, ex_zero : EX opcode and ALU zero flag (branch resolution)
//   mem_req, mem_ready : MEM access outstanding / completing this cycle
//   stall              : hold PC and IF/ID
//   bubble             : insert NOP into ID/EX
//   flush              : clear IF/ID and ID/EX
//   hazard_state       : 00 IDLE, 01 FLUSH, 10 MEM_WAIT
//   mem_timeout        : sticky watchdog flag
//   stall_count        : saturating count of cycles with stall=1
module hazard_control_unit #(
  parameter int unsigned          REG_ADDR_W    = 5,
  parameter int unsigned          OPCODE_W      = 4,
  parameter logic [OPCODE_W-1:0]  BRANCH_OPCODE = 4'b1011,
  parameter int unsigned          FLUSH_CYCLES  = 2,
  parameter int unsigned          MEM_TIMEOUT   = 64,
  parameter int unsigned          CNT_W         = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memread,
  input  logic [OPCODE_W-1:0]   ex_opcode,
  input  logic                  ex_zero,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic [1:0]            hazard_state,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FLUSH    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);

  localparam bit             MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0] FLUSH_ONE    = FCW'(1);
  localparam logic [WCW-1:0] WAIT_MAX     = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_ONE     = WCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state;
  state_t           r_ret_state;
  logic [FCW-1:0]   r_flush_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_mem_hold;
  logic             w_load_use;
  logic             w_taken;
  state_t           w_eff_state;
  logic             w_stall;
  logic             w_bubble;
  logic             w_flush;
  state_t           w_nxt_state;
  state_t           w_nxt_ret;
  logic [FCW-1:0]   w_nxt_flush_cnt;
  logic [WCW-1:0]   w_nxt_wait_cnt;
  logic             w_nxt_timeout;

  assign w_mem_hold = mem_req & ~mem_ready;
  assign w_taken    = (ex_opcode == BRANCH_OPCODE) & ~ex_zero;
  assign w_load_use = ex_memread & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Once the memory hold drops, MEM_WAIT behaves as the saved state in that
  // same cycle, so a pending flush resumes without a dead cycle.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

  always_comb begin
    w_stall         = 1'b0;
    w_bubble        = 1'b0;
    w_flush         = 1'b0;
    w_nxt_state     = r_state;
    w_nxt_ret       = r_ret_state;
    w_nxt_flush_cnt = r_flush_cnt;
    w_nxt_wait_cnt  = r_wait_cnt;
    w_nxt_timeout   = r_mem_timeout;

    if ((r_state == ST_MEM_WAIT) && w_mem_hold) begin
      w_stall = 1'b1;
      if (r_wait_cnt != WAIT_MAX) begin
        w_nxt_wait_cnt = r_wait_cnt + WAIT_ONE;
      end
    end else begin
      w_nxt_wait_cnt = '0;
      case (w_eff_state)
        ST_FLUSH: begin
          if (w_mem_hold) begin
            // Flush counter is frozen while memory holds the pipeline.
            w_stall        = 1'b1;
            w_nxt_state    = ST_MEM_WAIT;
            w_nxt_ret      = ST_FLUSH;
            w_nxt_wait_cnt = WAIT_ONE;
          end else begin
            w_flush = 1'b1;
            if (r_flush_cnt == FLUSH_ONE) begin
              w_nxt_state     = ST_IDLE;
              w_nxt_flush_cnt = '0;
            end else begin
              w_nxt_state     = ST_FLUSH;
              w_nxt_flush_cnt = r_flush_cnt - FLUSH_ONE;
            end
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
          if (w_mem_hold) begin
            w_stall        = 1'b1;
            w_nxt_state    = ST_MEM_WAIT;
            w_nxt_ret      = ST_IDLE;
            w_nxt_wait_cnt = WAIT_ONE;
          end else if (w_taken) begin
            // A taken branch discards the ID instruction, so any coincident
            // load-use hazard is irrelevant.
            w_flush = 1'b1;
            if (MULTI_FLUSH) begin
              w_nxt_state     = ST_FLUSH;
              w_nxt_flush_cnt = FLUSH_RELOAD;
            end
          end else if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
      endcase
    end

    if ((w_nxt_state == ST_MEM_WAIT) && (w_nxt_wait_cnt == WAIT_MAX)) begin
      w_nxt_timeout = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ret_state   <= ST_IDLE;
      r_flush_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_ret_state   <= w_nxt_ret;
      r_flush_cnt   <= w_nxt_flush_cnt;
      r_wait_cnt    <= w_nxt_wait_cnt;
      r_mem_timeout <= w_nxt_timeout;
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end
    end
  end

  // Control outputs are Mealy; gate them so they read 0 while reset is held.
  assign stall        = w_stall  & reset_n;
  assign bubble       = w_bubble & reset_n;
  assign flush        = w_flush  & reset_n;
  assign hazard_state = r_state;
  assign mem_timeout  = r_mem_timeout;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit
//   Self-checking bench for hazard_control_unit with FLUSH_CYCLES=2 and
//   MEM_TIMEOUT=4: a directed vector table, hand-written timeout and async
//   reset sequences, then randomized stimulus against a behavioural model.
module tb_hazard_control_unit;

  logic        clock;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_memread, ex_zero;
  logic [3:0]  ex_opcode;
  logic        mem_req, mem_ready;
  logic        stall, bubble, flush, mem_timeout;
  logic [1:0]  hazard_state;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  hazard_control_unit #(
    .REG_ADDR_W   (5),
    .OPCODE_W     (4),
    .BRANCH_OPCODE(4'b1011),
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_W        (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_opcode   (ex_opcode),
    .ex_zero     (ex_zero),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .bubble      (bubble),
    .flush       (flush),
    .hazard_state(hazard_state),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        mr;
    logic [3:0]  op;
    logic        z, req, rdy;
    logic        st, bu, fl;
    logic [1:0]  hs;
    logic        to;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int rd, int mr,
                              int op, int z, int req, int rdy,
                              int st, int bu, int fl, int hs, int to, int cnt);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.mr = 1'(mr); v.op = 4'(op); v.z = 1'(z);
    v.req = 1'(req); v.rdy = 1'(rdy);
    v.st = 1'(st); v.bu = 1'(bu); v.fl = 1'(fl); v.hs = 2'(hs);
    v.to = 1'(to); v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_memread = v.mr; ex_opcode = v.op; ex_zero = v.z;
    mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic idle_inputs();
    drive(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0));
  endtask

  task automatic chk(input string nm, input logic e_st, input logic e_bu,
                     input logic e_fl, input logic [1:0] e_hs, input logic e_to,
                     input logic [15:0] e_cnt);
    logic [21:0] act, exp_v;
    act   = {stall, bubble, flush, hazard_state, mem_timeout, stall_count};
    exp_v = {e_st, e_bu, e_fl, e_hs, e_to, e_cnt};
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got st=%b bu=%b fl=%b hs=%b to=%b cnt=%0d, want st=%b bu=%b fl=%b hs=%b to=%b cnt=%0d",
               nm, stall, bubble, flush, hazard_state, mem_timeout, stall_count,
               e_st, e_bu, e_fl, e_hs, e_to, e_cnt);
    end
  endtask

  // Behavioural model: flush_left counts flush cycles still owed, waiting
  // marks an open memory hold, waited counts its length.
  int m_flush_left, m_waited, m_stalls;
  bit m_waiting, m_tmo;

  task automatic model_reset();
    m_flush_left = 0; m_waited = 0; m_stalls = 0; m_waiting = 0; m_tmo = 0;
  endtask

  task automatic model_check_step(input string nm);
    logic hold, lu, tk, e_st, e_bu, e_fl;
    logic [1:0] e_hs;
    hold = mem_req && !mem_ready;
    tk   = (ex_opcode == 4'b1011) && !ex_zero;
    lu   = ex_memread && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e_st = 0; e_bu = 0; e_fl = 0;
    if (hold)                  e_st = 1;
    else if (m_flush_left > 0) e_fl = 1;
    else if (tk)               e_fl = 1;
    else if (lu) begin e_st = 1; e_bu = 1; end
    e_hs = m_waiting ? 2'd2 : ((m_flush_left > 0) ? 2'd1 : 2'd0);
    chk(nm, e_st, e_bu, e_fl, e_hs, m_tmo, 16'(m_stalls));
    if (hold) begin
      m_waited  = m_waiting ? ((m_waited < 4) ? m_waited + 1 : 4) : 1;
      m_waiting = 1;
      if (m_waited >= 4) m_tmo = 1;
    end else begin
      m_waiting = 0;
      if (m_flush_left > 0) m_flush_left--;
      else if (tk)          m_flush_left = 2 - 1;
    end
    if (e_st && m_stalls < 65535) m_stalls++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    // in: rs1 rs2 u1 u2 rd mr op z req rdy | out: st bu fl hs to cnt
    tbl[0]  = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(0,5,0,1,5,1, 0,1,0,0, 1,1,0,0,0,0);
    tbl[2]  = mk(0,5,0,1,5,0, 0,1,0,0, 0,0,0,0,0,1);
    tbl[3]  = mk(0,0,1,0,0,1, 0,1,0,0, 0,0,0,0,0,1);
    tbl[4]  = mk(7,0,0,0,7,1, 0,1,0,0, 0,0,0,0,0,1);
    tbl[5]  = mk(7,0,1,0,7,1, 0,1,0,0, 1,1,0,0,0,1);
    tbl[6]  = mk(0,0,0,0,0,0,11,1,0,0, 0,0,0,0,0,2);
    tbl[7]  = mk(0,0,0,0,0,0,11,0,0,0, 0,0,1,0,0,2);
    tbl[8]  = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,1,1,0,2);
    tbl[9]  = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,2);
    tbl[10] = mk(0,5,0,1,5,1,11,0,0,0, 0,0,1,0,0,2);
    tbl[11] = mk(0,5,0,1,5,1, 0,1,0,0, 0,0,1,1,0,2);
    tbl[12] = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,2);
    tbl[13] = mk(0,0,0,0,0,0,11,0,0,0, 0,0,1,0,0,2);
    tbl[14] = mk(0,0,0,0,0,0, 0,1,1,0, 1,0,0,1,0,2);
    tbl[15] = mk(0,0,0,0,0,0, 0,1,1,0, 1,0,0,2,0,3);
    tbl[16] = mk(0,0,0,0,0,0, 0,1,1,0, 1,0,0,2,0,4);
    tbl[17] = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,1,2,0,5);
    tbl[18] = mk(0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,5);
    tbl[19] = mk(0,0,0,0,0,0, 0,1,1,1, 0,0,0,0,0,5);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("table[%0d]", i), tbl[i].st, tbl[i].bu, tbl[i].fl,
          tbl[i].hs, tbl[i].to, tbl[i].cnt);
      @(negedge clock);
    end

    // Watchdog: six hold cycles with MEM_TIMEOUT=4.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(mk(0,0,0,0,0,0, 0,1,1,0, 0,0,0,0,0,0));
      #1;
      chk($sformatf("timeout_hold[%0d]", k), 1'b1, 1'b0, 1'b0,
          (k == 1) ? 2'd0 : 2'd2, (k >= 5), 16'(k - 1));
      @(negedge clock);
    end
    mem_ready = 1'b1;
    #1 chk("timeout_release", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 16'd6);
    @(negedge clock);
    idle_inputs();
    #1 chk("timeout_sticky", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'd6);

    // Async reset while in MEM_WAIT, between clock edges.
    @(negedge clock);
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 chk("rst_pre_hold", 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'd6);
    @(negedge clock);
    #1 chk("rst_pre_wait", 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 16'd7);
    ex_opcode = 4'b1011; ex_zero = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("async_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    @(negedge clock);
    idle_inputs();
    reset_n = 1'b1;
    #1 chk("after_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0);

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit burst;
      burst       = (i % 400) < 8;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 1));
      ex_opcode   = ($urandom_range(0, 3) == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
      ex_zero     = 1'($urandom_range(0, 1));
      mem_req     = burst ? 1'b1 : ($urandom_range(0, 3) == 0);
      mem_ready   = burst ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      model_check_step($sformatf("random[%0d]", i));
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
